// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier
// Sequential radix-2 Booth multiplier producing a 2*WIDTH-bit product,
// signed or unsigned, one Booth step per clock. Operands are widened to
// WIDTH+1 bits so unsigned full-scale values and the most negative signed
// value both run through the same two's-complement datapath without overflow.
// Valid/ready handshakes on input and output; one operation in flight.

module booth_seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    // Extended datapath width and a step counter wide enough to hold WIDTH+1.
    localparam int EW = WIDTH + 1;
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_q,     state_d;
    logic [EW-1:0]        m_q,         m_d;
    logic [EW-1:0]        acc_q,       acc_d;
    logic [EW-1:0]        q_q,         q_d;
    logic                 q1_q,        q1_d;
    logic [CW-1:0]        count_q,     count_d;
    logic [2*WIDTH-1:0]   product_q,   product_d;
    logic                 in_ready_q,  in_ready_d;
    logic                 out_valid_q, out_valid_d;

    // Operand extension: the extra top bit is the sign for signed operations
    // and zero for unsigned, so both modes become plain signed arithmetic.
    logic [EW-1:0] a_ext;
    logic [EW-1:0] b_ext;

    assign a_ext = {signed_op & a[WIDTH-1], a};
    assign b_ext = {signed_op & b[WIDTH-1], b};

    // Booth recoding of the current multiplier bit pair {Q[0], Q_1}.
    // 10 -> subtract M, 01 -> add M, 00/11 -> keep ACC.
    logic          sub_sel;
    logic          op_active;
    logic [EW-1:0] addend;

    assign sub_sel   = q_q[0] & ~q1_q;
    assign op_active = q_q[0] ^ q1_q;
    assign addend    = m_q ^ {EW{sub_sel}};

    // Ripple-carry add/subtract: subtraction is ACC + ~M + 1, with the +1
    // entering as the carry into bit 0. The carry out of the top bit is
    // dropped because the widened ACC cannot overflow.
    logic [EW-1:0] sum;
    logic [EW-1:0] carry;

    assign carry[0] = sub_sel;

    generate
        for (genvar gi = 0; gi < EW; gi++) begin : g_addsub
            assign sum[gi] = acc_q[gi] ^ addend[gi] ^ carry[gi];
            if (gi < EW - 1) begin : g_carry
                assign carry[gi+1] = (acc_q[gi] & addend[gi])
                                   | (acc_q[gi] & carry[gi])
                                   | (addend[gi] & carry[gi]);
            end
        end
    endgenerate

    // Arithmetic right shift of {ACC, Q, Q_1} after the optional add/sub.
    logic [EW-1:0]      alu;
    logic [EW-1:0]      acc_sh;
    logic [EW-1:0]      q_sh;
    logic               q1_sh;
    logic [2*WIDTH-1:0] step_product;

    assign alu          = op_active ? sum : acc_q;
    assign acc_sh       = {alu[EW-1], alu[EW-1:1]};
    assign q_sh         = {alu[0], q_q[EW-1:1]};
    assign q1_sh        = q_q[0];
    // The low 2*WIDTH bits of the shifted {ACC, Q}; the top two are discarded.
    assign step_product = {acc_sh[WIDTH-2:0], q_sh};

    logic [CW-1:0] count_inc;
    logic          last_step;

    assign count_inc = count_q + CW'(1);
    assign last_step = (count_inc == CW'(EW));

    // Next-state and datapath update for the IDLE -> CALC -> DONE sequence.
    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        acc_d       = acc_q;
        q_d         = q_q;
        q1_d        = q1_q;
        count_d     = count_q;
        product_d   = product_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    m_d        = a_ext;
                    q_d        = b_ext;
                    acc_d      = '0;
                    q1_d       = 1'b0;
                    count_d    = '0;
                    state_d    = ST_CALC;
                    in_ready_d = 1'b0;
                end
            end
            ST_CALC: begin
                acc_d   = acc_sh;
                q_d     = q_sh;
                q1_d    = q1_sh;
                count_d = count_inc;
                if (last_step) begin
                    state_d     = ST_DONE;
                    product_d   = step_product;
                    out_valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                // in_ready stays low through the output handshake cycle.
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State register; reset aborts any operation in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            m_q         <= '0;
            acc_q       <= '0;
            q_q         <= '0;
            q1_q        <= 1'b0;
            count_q     <= '0;
            product_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            acc_q       <= acc_d;
            q_q         <= q_d;
            q1_q        <= q1_d;
            count_q     <= count_d;
            product_q   <= product_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// tb_booth_seq_multiplier
// Directed vectors with hand-computed products for the Booth multiplier,
// including latency, backpressure, ignored inputs while busy and mid-op reset.

module tb_booth_seq_multiplier;

    localparam int WIDTH = 32;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_op;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;

    int vectors_applied = 0;
    int miscompares     = 0;

    booth_seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .signed_op (signed_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors_applied++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    // Present operands in IDLE and complete the input handshake.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic s, input string tag);
        @(negedge clk);
        check_val({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        a         = av;
        b         = bv;
        signed_op = s;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    // Wait (bounded) for out_valid, then check latency and product.
    task automatic wait_result(input string tag, input int exp_cycles, input logic [63:0] exp);
        int cycles = 0;
        while (!out_valid && cycles < 200) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
        end
        check_val({tag, ".latency"}, 64'(cycles), 64'(exp_cycles));
        check_val({tag, ".product"}, product, exp);
        check_val({tag, ".in_ready_in_done"}, 64'(in_ready), 64'd0);
    endtask

    // Output handshake, then confirm return to IDLE.
    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_val({tag, ".out_valid_after"}, 64'(out_valid), 64'd0);
        check_val({tag, ".in_ready_after"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic s,
                          input logic [63:0] exp, input string tag);
        issue(av, bv, s, tag);
        wait_result(tag, 33, exp);
        drain(tag);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        signed_op = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("reset.in_ready", 64'(in_ready), 64'd1);
        check_val("reset.out_valid", 64'(out_valid), 64'd0);
        check_val("reset.product", product, 64'd0);
        rst = 1'b0;

        run_op(32'd7,         32'd3,         1'b1, 64'h0000_0000_0000_0015, "s7x3");
        run_op(32'hFFFF_FFFB, 32'd3,         1'b1, 64'hFFFF_FFFF_FFFF_FFF1, "sm5x3");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "sminxmin");
        run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 64'hC000_0000_8000_0000, "sminxmax");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "uffxff");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, "sm1xm1");
        run_op(32'h8000_0000, 32'd2,         1'b0, 64'h0000_0001_0000_0000, "u2p31x2");
        run_op(32'h8000_0000, 32'd2,         1'b1, 64'hFFFF_FFFF_0000_0000, "sm2p31x2");

        // Backpressure, with in_valid pulses during CALC and DONE ignored.
        issue(32'd12, 32'hFFFF_FFF8, 1'b1, "bp");
        a = 32'd1; b = 32'd1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_val("bp.in_ready_calc", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        wait_result("bp", 28, 64'hFFFF_FFFF_FFFF_FFA0);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            @(posedge clk);
            @(negedge clk);
            check_val("bp.out_valid_held", 64'(out_valid), 64'd1);
            check_val("bp.product_held", product, 64'hFFFF_FFFF_FFFF_FFA0);
        end
        in_valid = 1'b1;
        drain("bp");
        in_valid = 1'b0;
        check_val("bp.product_kept", product, 64'hFFFF_FFFF_FFFF_FFA0);

        // Reset in the middle of CALC aborts the operation.
        issue(32'd2147483647, 32'd2, 1'b1, "rs");
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_val("rs.in_ready", 64'(in_ready), 64'd1);
        check_val("rs.out_valid", 64'(out_valid), 64'd0);
        check_val("rs.product", product, 64'd0);
        run_op(32'd0,          32'd0, 1'b1, 64'h0000_0000_0000_0000, "zero");
        run_op(32'd2147483647, 32'd2, 1'b1, 64'h0000_0000_FFFF_FFFE, "maxx2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
